// File: rtl/char_anim_pkg.sv
// Shared types, defaults and elaboration helpers for the sprite animation sequencer.
package char_anim_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } anim_state_e;

    // Pose index width seen by the VGA address generator (strips hold up to 8 poses).
    localparam int IDX_W = 3;

    localparam int DEF_IDLE_FRAMES = 4;
    localparam int DEF_WALK_FRAMES = 6;
    localparam int DEF_IDLE_DIV    = 8;
    localparam int DEF_WALK_DIV    = 5;

    // A strip must hold at least one pose and fit the 3-bit pose index.
    function automatic bit frames_ok(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

    // Divider register width: clog2 of the larger divider, never narrower than 1 bit.
    function automatic int div_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/anim_channel.sv
// One character: direction decode, IDLE/WALK FSM, frame divider and pose counter.
// All state advances only on an unfrozen frame tick.
module anim_channel
    import char_anim_pkg::*;
#(
    parameter int IDLE_FRAMES = DEF_IDLE_FRAMES,
    parameter int WALK_FRAMES = DEF_WALK_FRAMES,
    parameter int IDLE_DIV    = DEF_IDLE_DIV,
    parameter int WALK_DIV    = DEF_WALK_DIV,
    parameter int DIV_W       = div_width(DEF_IDLE_DIV, DEF_WALK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             freeze_i,
    input  logic             left_i,
    input  logic             right_i,
    output logic [IDX_W-1:0] frame_idx_o,
    output logic             is_moving_o,
    output logic             face_left_o
);

    localparam logic [IDX_W-1:0] IDLE_LAST     = IDX_W'(IDLE_FRAMES - 1);
    localparam logic [IDX_W-1:0] WALK_LAST     = IDX_W'(WALK_FRAMES - 1);
    localparam logic [DIV_W-1:0] IDLE_DIV_LAST = DIV_W'(IDLE_DIV - 1);
    localparam logic [DIV_W-1:0] WALK_DIV_LAST = DIV_W'(WALK_DIV - 1);

    anim_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             face_q, face_d;

    logic             mv;
    logic             walking;
    logic [DIV_W-1:0] div_last;
    logic [IDX_W-1:0] idx_last;

    assign mv       = left_i ^ right_i;
    assign walking  = (state_q == ST_WALK);
    assign div_last = walking ? WALK_DIV_LAST : IDLE_DIV_LAST;
    assign idx_last = walking ? WALK_LAST : IDLE_LAST;

    // State register; every output is a direct register view so they only move on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            face_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            face_q  <= face_d;
        end
    end

    // Next state: a strip change restarts at pose 0 with a full divider period,
    // otherwise the divider counts video frames and wraps the pose counter.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        face_d  = face_q;
        if (tick_i && !freeze_i) begin
            // Neither or both directions leave the facing unchanged.
            if (left_i && !right_i) begin
                face_d = 1'b1;
            end else if (right_i && !left_i) begin
                face_d = 1'b0;
            end

            if (walking != mv) begin
                state_d = mv ? ST_WALK : ST_IDLE;
                div_d   = '0;
                idx_d   = '0;
            end else if (div_q == div_last) begin
                div_d = '0;
                idx_d = (idx_q == idx_last) ? '0 : idx_q + IDX_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign frame_idx_o = idx_q;
    assign is_moving_o = walking;
    assign face_left_o = face_q;

    // The pose index must stay inside the strip that is currently selected.
    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        walking ? (idx_q <= WALK_LAST) : (idx_q <= IDLE_LAST));

endmodule

// File: rtl/char_anim_ctrl.sv
// Per-frame animation sequencer for two sprites: synchronises vsync, derives a
// single-cycle frame tick from its rising edge and drives two animation channels.
module char_anim_ctrl
    import char_anim_pkg::*;
#(
    parameter int IDLE_FRAMES = DEF_IDLE_FRAMES,
    parameter int WALK_FRAMES = DEF_WALK_FRAMES,
    parameter int IDLE_DIV    = DEF_IDLE_DIV,
    parameter int WALK_DIV    = DEF_WALK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             left_0,
    input  logic             right_0,
    input  logic             left_1,
    input  logic             right_1,
    input  logic             freeze,
    output logic             frame_tick,
    output logic [IDX_W-1:0] frame_idx,
    output logic             is_moving,
    output logic             face_left,
    output logic [IDX_W-1:0] frame_idx_1,
    output logic             is_moving_1,
    output logic             face_left_1
);

    localparam int DIV_W = div_width(IDLE_DIV, WALK_DIV);

    logic sync1_q, sync2_q, prev_q, tick_q;
    logic tick_d;

    // Rising edge of the synchronised vsync; a long-held vsync yields a single tick.
    assign tick_d = sync2_q & ~prev_q;

    // Two-flop synchroniser followed by a registered edge detector (tick 3 edges after the rise).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= tick_d;
        end
    end

    assign frame_tick = tick_q;

    anim_channel #(
        .IDLE_FRAMES (IDLE_FRAMES),
        .WALK_FRAMES (WALK_FRAMES),
        .IDLE_DIV    (IDLE_DIV),
        .WALK_DIV    (WALK_DIV),
        .DIV_W       (DIV_W)
    ) u_ch0 (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick_q),
        .freeze_i    (freeze),
        .left_i      (left_0),
        .right_i     (right_0),
        .frame_idx_o (frame_idx),
        .is_moving_o (is_moving),
        .face_left_o (face_left)
    );

    anim_channel #(
        .IDLE_FRAMES (IDLE_FRAMES),
        .WALK_FRAMES (WALK_FRAMES),
        .IDLE_DIV    (IDLE_DIV),
        .WALK_DIV    (WALK_DIV),
        .DIV_W       (DIV_W)
    ) u_ch1 (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick_q),
        .freeze_i    (freeze),
        .left_i      (left_1),
        .right_i     (right_1),
        .frame_idx_o (frame_idx_1),
        .is_moving_o (is_moving_1),
        .face_left_o (face_left_1)
    );

    // Parameter sanity: strips must fit the pose index and dividers must be non-zero.
    a_params: assert property (@(posedge clk)
        frames_ok(IDLE_FRAMES) && frames_ok(WALK_FRAMES) && (IDLE_DIV >= 1) && (WALK_DIV >= 1));

endmodule

// File: tb/tb_char_anim_ctrl.sv
// Scoreboard bench: stimulus pushes the hand-derived outputs expected after each
// vsync; a monitor pops one entry per frame_tick and compares.
module tb_char_anim_ctrl;

    typedef struct packed {
        logic [2:0] i0;
        logic       m0;
        logic       f0;
        logic [2:0] i1;
        logic       m1;
        logic       f1;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       left_0 = 1'b0, right_0 = 1'b0, left_1 = 1'b0, right_1 = 1'b0;
    logic       freeze = 1'b0;
    logic       frame_tick;
    logic [2:0] frame_idx, frame_idx_1;
    logic       is_moving, face_left, is_moving_1, face_left_1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   tick_no  = 0;
    int   tick_cnt = 0;
    int   tick_cyc = 0;
    int   rise_cyc = 0;
    logic cnt_en   = 1'b0;
    exp_t exp_q[$];
    exp_t e_mon, act_mon;

    char_anim_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .left_0      (left_0),
        .right_0     (right_0),
        .left_1      (left_1),
        .right_1     (right_1),
        .freeze      (freeze),
        .frame_tick  (frame_tick),
        .frame_idx   (frame_idx),
        .is_moving   (is_moving),
        .face_left   (face_left),
        .frame_idx_1 (frame_idx_1),
        .is_moving_1 (is_moving_1),
        .face_left_1 (face_left_1)
    );

    // Gateable 25 MHz clock so reset can be applied with the clock stopped.
    always begin
        #20;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(int i0, bit m0, bit f0, int i1, bit m1, bit f1);
        exp_t r;
        r.i0 = 3'(i0); r.m0 = m0; r.f0 = f0;
        r.i1 = 3'(i1); r.m1 = m1; r.f1 = f1;
        return r;
    endfunction

    function automatic exp_t cur_out();
        exp_t r;
        r.i0 = frame_idx;   r.m0 = is_moving;   r.f0 = face_left;
        r.i1 = frame_idx_1; r.m1 = is_moving_1; r.f1 = face_left_1;
        return r;
    endfunction

    // One video frame: set levels, queue the expected result, pulse vsync.
    task automatic do_tick(input logic l0, r0, l1, r1, frz, input exp_t e);
        left_0 = l0; right_0 = r0; left_1 = l1; right_1 = r1; freeze = frz;
        exp_q.push_back(e);
        @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: on each frame_tick compare the outputs registered on that tick.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (cnt_en) begin
                    tick_cnt++;
                    tick_cyc = cyc;
                end
                @(posedge clk);
                #1;
                act_mon = cur_out();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tick: outputs=%h with nothing expected", act_mon);
                end else begin
                    e_mon = exp_q.pop_front();
                    tick_no++;
                    if (act_mon !== e_mon) begin
                        n_fail++;
                        $display("FAIL tick_%0d: got idx0=%0d mv0=%0d fl0=%0d idx1=%0d mv1=%0d fl1=%0d, want idx0=%0d mv0=%0d fl0=%0d idx1=%0d mv1=%0d fl1=%0d",
                                 tick_no, act_mon.i0, act_mon.m0, act_mon.f0, act_mon.i1, act_mon.m1, act_mon.f1,
                                 e_mon.i0, e_mon.m0, e_mon.f0, e_mon.i1, e_mon.m1, e_mon.f1);
                    end
                end
                n_checks++;
                if (frame_tick !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_width: frame_tick=%b one cycle later, want 0", frame_tick);
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: run did not complete, %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cur_out(), frame_tick} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, want 0", {cur_out(), frame_tick});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Idle strip: 8 frames per pose, 4 poses
        for (int k = 1; k <= 33; k++)
            do_tick(0, 0, 0, 0, 0, mk((k / 8) % 4, 0, 0, (k / 8) % 4, 0, 0));

        // Char 0 walks right: 5 frames per pose, 6 poses; char 1 keeps idling
        for (int n = 1; n <= 31; n++)
            do_tick(0, 1, 0, 0, 0, mk(((n - 1) / 5) % 6, 1, 0, ((33 + n) / 8) % 4, 0, 0));

        // Direction reversal keeps walking, only the facing flips
        for (int n = 32; n <= 38; n++)
            do_tick(1, 0, 0, 0, 0, mk(((n - 1) / 5) % 6, 1, 1, ((33 + n) / 8) % 4, 0, 0));

        // Both directions pressed: idle, pose 0, facing held left
        do_tick(1, 1, 0, 0, 0, mk(0, 0, 1, 1, 0, 0));

        // Char 1 walks left to pose 3, one frame into the divider
        for (int p = 1; p <= 17; p++)
            do_tick(0, 0, 1, 0, 0, mk((p / 8) % 4, 0, 1, ((p - 1) / 5) % 6, 1, 1));
        // Release mid-divider: idle at pose 0, then pose 1 exactly 8 ticks later
        do_tick(0, 0, 0, 0, 0, mk((18 / 8) % 4, 0, 1, 0, 0, 1));
        for (int q = 1; q <= 8; q++)
            do_tick(0, 0, 0, 0, 0, mk(((18 + q) / 8) % 4, 0, 1, (q / 8) % 4, 0, 1));

        // Char 0 walks right up to pose 2, one frame into the divider
        for (int w = 1; w <= 12; w++)
            do_tick(0, 1, 0, 0, 0, mk(((w - 1) / 5) % 6, 1, 0, ((8 + w) / 8) % 4, 0, 1));
        // Frozen: inputs that would change state/facing are ignored
        for (int j = 1; j <= 20; j++) begin
            if (j % 2 == 1) do_tick(1, 0, 0, 1, 1, mk(2, 1, 0, 2, 0, 1));
            else            do_tick(0, 0, 1, 1, 1, mk(2, 1, 0, 2, 0, 1));
        end
        // Resume with the held divider value
        for (int w = 13; w <= 17; w++)
            do_tick(0, 1, 0, 0, 0, mk(((w - 1) / 5) % 6, 1, 0, ((8 + w) / 8) % 4, 0, 1));

        // Reset mid-walk with the clock stopped
        @(negedge clk);
        clk_run = 1'b0;
        #100;
        rst = 1'b1;
        #5;
        n_checks++;
        if ({cur_out(), frame_tick} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h with clock stopped, want 0", {cur_out(), frame_tick});
        end
        #50;
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        left_0 = 0; right_0 = 0; left_1 = 0; right_1 = 0; freeze = 0;
        repeat (3) @(negedge clk);

        // vsync held high for 1000 clocks: one tick, 3 edges after the rise
        tick_cnt = 0;
        cnt_en = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        vsync = 1'b1;
        rise_cyc = cyc;
        repeat (1000) @(negedge clk);
        vsync = 1'b0;
        repeat (10) @(negedge clk);
        cnt_en = 1'b0;
        n_checks++;
        if (tick_cnt != 1) begin
            n_fail++;
            $display("FAIL held_vsync_count: got %0d ticks, want 1", tick_cnt);
        end
        n_checks++;
        if (tick_cyc - rise_cyc != 3) begin
            n_fail++;
            $display("FAIL tick_latency: got %0d edges, want 3", tick_cyc - rise_cyc);
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expected ticks never seen, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
